hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the decode/register-read stage of the 3-stage RV32I core.
- Generates the stall, bubble and fetch-flush controls for the decode/read register, and the operand forwarding selects.
- Tracks one outstanding load, taken jumps/branches and CSR serialization.
- Sits beside the decode/read stage. Receives decoded fields of the instruction in ID, the control fields of the instruction in EX, and the data-memory handshake.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl_fwd_unit.sv | 26 ++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode/read hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_FLUSH     = 2'd1,
    S_CSR_DRAIN = 2'd2
  } ctrl_state_t;

  localparam logic [SEL_W-1:0] FWD_REG = 2'd0;
  localparam logic [SEL_W-1:0] FWD_EX  = 2'd1;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'd2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle between the ID/EX/WB stages and hazard_ctrl.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_is_load;
  logic             id_is_csr;
  logic             ex_valid;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_we;
  logic             ex_mem_rr;
  logic             ex_redirect;
  logic             dmem_resp_valid;
  logic             wb_we;
  logic [REG_W-1:0] wb_rd;
  logic             fetch_stall;
  logic             dr_stall;
  logic             bubble;
  logic             fetch_flush;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_load, id_is_csr,
    output ex_valid, ex_rd, ex_reg_we, ex_mem_rr, ex_redirect,
    output dmem_resp_valid, wb_we, wb_rd,
    input  fetch_stall, dr_stall, bubble, fetch_flush, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_load, id_is_csr,
    input  ex_valid, ex_rd, ex_reg_we, ex_mem_rr, ex_redirect,
    input  dmem_resp_valid, wb_we, wb_rd,
    output fetch_stall, dr_stall, bubble, fetch_flush, fwd_a_sel, fwd_b_sel
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one source register; EX beats WB, x0 never forwards.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             ex_valid,
  input  logic             ex_reg_we,
  input  logic             ex_mem_rr,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  output logic [SEL_W-1:0] sel_c
);

  always_comb begin
    sel_c = FWD_REG;
    if (rs != '0) begin
      if (ex_valid && ex_reg_we && !ex_mem_rr && (ex_rd == rs)) begin
        sel_c = FWD_EX;
      end else if (wb_we && (wb_rd == rs)) begin
        sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode/read hazard controller: load-use and CSR stalls, redirect flush, forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_bubble_cycles,
  output logic [CNT_W-1:0] perf_flush_events
`endif
);

  if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 7)) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..7");
  end
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  // Redirect cycle itself is the first flush cycle, so S_FLUSH covers the remainder.
  localparam logic [FCNT_W-1:0] FLUSH_LOAD =
    (FLUSH_CYCLES > 1) ? FCNT_W'(FLUSH_CYCLES - 2) : '0;

  ctrl_state_t       state, state_nxt;
  logic [FCNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic              ld_pend;
  logic [REG_W-1:0]  ld_rd;

  logic ex_load_wr, ld_live, match_rs1, match_rs2, load_use, second_load, csr_wait;
  logic csr_hold, hz_stall, ld_set;
  logic fetch_stall_c, bubble_c, fetch_flush_c, dr_stall_c;
  logic [SEL_W-1:0] sel_a_c, sel_b_c;

  assign ex_load_wr  = bus.ex_valid & bus.ex_reg_we & bus.ex_mem_rr;
  assign ld_live     = ld_pend & ~bus.dmem_resp_valid;
  assign match_rs1   = (bus.id_rs1 != '0) & bus.id_valid & bus.id_uses_rs1 &
                       ((ex_load_wr & (bus.ex_rd == bus.id_rs1)) | (ld_live & (ld_rd == bus.id_rs1)));
  assign match_rs2   = (bus.id_rs2 != '0) & bus.id_valid & bus.id_uses_rs2 &
                       ((ex_load_wr & (bus.ex_rd == bus.id_rs2)) | (ld_live & (ld_rd == bus.id_rs2)));
  assign load_use    = match_rs1 | match_rs2;
  assign second_load = bus.id_is_load & bus.id_valid & ld_live;
  assign csr_wait    = bus.id_is_csr & bus.id_valid & (bus.ex_valid | ld_pend);
  assign csr_hold    = (state == S_CSR_DRAIN) & (bus.ex_valid | ld_pend);
  assign hz_stall    = load_use | second_load;
  assign dr_stall_c  = 1'b0;
  assign ld_set      = bus.ex_valid & bus.ex_mem_rr & ~dr_stall_c;

  // State register and pending-load tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      flush_cnt <= '0;
      ld_pend   <= 1'b0;
      ld_rd     <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (ld_set) begin
        ld_pend <= 1'b1;
        ld_rd   <= bus.ex_rd;
      end else if (bus.dmem_resp_valid) begin
        ld_pend <= 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    if (bus.ex_redirect) begin
      state_nxt     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (state)
        S_FLUSH: begin
          if (flush_cnt == '0) state_nxt = S_RUN;
          else                 flush_cnt_nxt = flush_cnt - FCNT_W'(1);
        end
        S_CSR_DRAIN: begin
          if (!bus.ex_valid && !ld_pend) state_nxt = S_RUN;
        end
        default: begin
          if (!hz_stall && csr_wait) state_nxt = S_CSR_DRAIN;
        end
      endcase
    end
  end

  // Control outputs.
  always_comb begin
    fetch_stall_c = 1'b0;
    bubble_c      = 1'b0;
    fetch_flush_c = 1'b0;
    if (rst) begin
      fetch_stall_c = 1'b0;
    end else if (bus.ex_redirect || (state == S_FLUSH)) begin
      fetch_flush_c = 1'b1;
      bubble_c      = 1'b1;
    end else if (hz_stall || csr_wait || csr_hold) begin
      fetch_stall_c = 1'b1;
      bubble_c      = 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .rs(bus.id_rs1), .ex_valid(bus.ex_valid), .ex_reg_we(bus.ex_reg_we),
    .ex_mem_rr(bus.ex_mem_rr), .ex_rd(bus.ex_rd), .wb_we(bus.wb_we),
    .wb_rd(bus.wb_rd), .sel_c(sel_a_c)
  );

  fwd_unit u_fwd_b (
    .rs(bus.id_rs2), .ex_valid(bus.ex_valid), .ex_reg_we(bus.ex_reg_we),
    .ex_mem_rr(bus.ex_mem_rr), .ex_rd(bus.ex_rd), .wb_we(bus.wb_we),
    .wb_rd(bus.wb_rd), .sel_c(sel_b_c)
  );

  assign bus.fetch_stall = fetch_stall_c;
  assign bus.bubble      = bubble_c;
  assign bus.fetch_flush = fetch_flush_c;
  assign bus.dr_stall    = dr_stall_c;
  assign bus.fwd_a_sel   = rst ? FWD_REG : sel_a_c;
  assign bus.fwd_b_sel   = rst ? FWD_REG : sel_b_c;

`ifdef HAZARD_PERF_CNT_EN
  logic redirect_q;

  // Wrapping event counters; flush events count redirect rising edges only.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q         <= 1'b0;
      perf_stall_cycles  <= '0;
      perf_bubble_cycles <= '0;
      perf_flush_events  <= '0;
    end else begin
      redirect_q <= bus.ex_redirect;
      if (fetch_stall_c)                     perf_stall_cycles  <= perf_stall_cycles + CNT_W'(1);
      if (bubble_c)                          perf_bubble_cycles <= perf_bubble_cycles + CNT_W'(1);
      if (bus.ex_redirect && !redirect_q)    perf_flush_events  <= perf_flush_events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl built with FLUSH_CYCLES = 3.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned TB_CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [TB_CNT_W-1:0] perf_stall_cycles, perf_bubble_cycles, perf_flush_events;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(TB_CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(hif.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_bubble_cycles(perf_bubble_cycles),
    .perf_flush_events(perf_flush_events)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic stall, input logic bub, input logic flush);
    chk({tag, ".fetch_stall"}, 32'(hif.fetch_stall), 32'(stall));
    chk({tag, ".bubble"},      32'(hif.bubble),      32'(bub));
    chk({tag, ".fetch_flush"}, 32'(hif.fetch_flush), 32'(flush));
    chk({tag, ".dr_stall"},    32'(hif.dr_stall),    32'd0);
  endtask

  task automatic idle();
    hif.id_valid = 1'b0; hif.id_rs1 = '0; hif.id_rs2 = '0;
    hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.id_is_load = 1'b0; hif.id_is_csr = 1'b0;
    hif.ex_valid = 1'b0; hif.ex_rd = '0; hif.ex_reg_we = 1'b0;
    hif.ex_mem_rr = 1'b0; hif.ex_redirect = 1'b0;
    hif.dmem_resp_valid = 1'b0; hif.wb_we = 1'b0; hif.wb_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    hif.ex_valid = 1'b1; hif.ex_reg_we = 1'b1; hif.ex_mem_rr = 1'b1; hif.ex_rd = rd;
  endtask

  task automatic ex_clear();
    hif.ex_valid = 1'b0; hif.ex_reg_we = 1'b0; hif.ex_mem_rr = 1'b0; hif.ex_rd = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    // Reset dominates an active redirect and a load-use pattern.
    hif.ex_redirect = 1'b1;
    ex_load(5'd5);
    hif.id_valid = 1'b1; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    hif.wb_we = 1'b1; hif.wb_rd = 5'd5;
    #1;
    chk_ctl("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_REG));
`ifdef HAZARD_PERF_CNT_EN
    chk("rst.perf_stall", perf_stall_cycles, 32'd0);
`endif

    // Load-use on x5, response three cycles later.
    tick(); rst = 1'b0; idle();
    ex_load(5'd5);
    hif.id_valid = 1'b1; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    #1; chk_ctl("lu_a", 1'b1, 1'b1, 1'b0);
    tick(); ex_clear();
    #1; chk_ctl("lu_b", 1'b1, 1'b1, 1'b0);
    tick();
    #1; chk_ctl("lu_c", 1'b1, 1'b1, 1'b0);
    tick(); hif.dmem_resp_valid = 1'b1; hif.wb_we = 1'b1; hif.wb_rd = 5'd5;
    #1; chk_ctl("lu_d", 1'b0, 1'b0, 1'b0);
    chk("lu_d.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_WB));
    tick(); hif.dmem_resp_valid = 1'b0; hif.wb_we = 1'b0;
    #1; chk_ctl("lu_e", 1'b0, 1'b0, 1'b0);
    chk("lu_e.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_REG));
`ifdef HAZARD_PERF_CNT_EN
    chk("lu.perf_stall", perf_stall_cycles, 32'd3);
    chk("lu.perf_bubble", perf_bubble_cycles, 32'd3);
`endif

    // Forwarding priority and x0 handling.
    tick(); idle();
    hif.ex_valid = 1'b1; hif.ex_reg_we = 1'b1; hif.ex_rd = 5'd7;
    hif.id_valid = 1'b1; hif.id_rs1 = 5'd3; hif.id_uses_rs1 = 1'b1;
    hif.id_rs2 = 5'd7; hif.id_uses_rs2 = 1'b1;
    hif.wb_we = 1'b1; hif.wb_rd = 5'd7;
    #1; chk("fw_ex.fwd_b", 32'(hif.fwd_b_sel), 32'(FWD_EX));
    chk("fw_ex.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_REG));
    chk_ctl("fw_ex", 1'b0, 1'b0, 1'b0);
    tick(); hif.id_rs2 = 5'd0; hif.ex_rd = 5'd0; hif.wb_rd = 5'd0;
    #1; chk("fw_x0.fwd_b", 32'(hif.fwd_b_sel), 32'(FWD_REG));
    tick(); hif.id_rs2 = 5'd7; hif.ex_rd = 5'd3; hif.wb_rd = 5'd7;
    #1; chk("fw_wb.fwd_b", 32'(hif.fwd_b_sel), 32'(FWD_WB));
    chk("fw_wb.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_EX));
    tick(); hif.ex_valid = 1'b0; hif.ex_rd = 5'd7;
    #1; chk("fw_exinv.fwd_b", 32'(hif.fwd_b_sel), 32'(FWD_WB));

    // Single redirect: three flush cycles.
    tick(); idle(); hif.ex_redirect = 1'b1;
    #1; chk_ctl("rd1_c1", 1'b0, 1'b1, 1'b1);
    tick(); hif.ex_redirect = 1'b0;
    #1; chk_ctl("rd1_c2", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rd1_c3", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rd1_c4", 1'b0, 1'b0, 1'b0);

    // Second redirect in cycle 2 extends flush through cycle 4.
    tick(); hif.ex_redirect = 1'b1;
    #1; chk_ctl("rd2_c1", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rd2_c2", 1'b0, 1'b1, 1'b1);
    tick(); hif.ex_redirect = 1'b0;
    #1; chk_ctl("rd2_c3", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rd2_c4", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rd2_c5", 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rd.perf_bubble", perf_bubble_cycles, 32'd10);
    chk("rd.perf_flush", perf_flush_events, 32'd2);
`endif

    // CSR waits for both EX and the pending load to drain.
    tick(); ex_load(5'd9);
    #1; chk_ctl("csr_l", 1'b0, 1'b0, 1'b0);
    tick(); hif.ex_valid = 1'b1; hif.ex_reg_we = 1'b1; hif.ex_mem_rr = 1'b0; hif.ex_rd = 5'd2;
    hif.id_valid = 1'b1; hif.id_is_csr = 1'b1;
    #1; chk_ctl("csr_m", 1'b1, 1'b1, 1'b0);
    tick(); ex_clear();
    #1; chk_ctl("csr_n", 1'b1, 1'b1, 1'b0);
    tick(); hif.dmem_resp_valid = 1'b1;
    #1; chk_ctl("csr_o", 1'b1, 1'b1, 1'b0);
    tick(); hif.dmem_resp_valid = 1'b0;
    #1; chk_ctl("csr_p", 1'b0, 1'b0, 1'b0);

    // Redirect leaves an older pending load intact.
    tick(); idle(); ex_load(5'd12);
    tick(); ex_clear(); hif.ex_redirect = 1'b1;
    hif.id_valid = 1'b1; hif.id_rs1 = 5'd12; hif.id_uses_rs1 = 1'b1;
    #1; chk_ctl("rl_s", 1'b0, 1'b1, 1'b1);
    tick(); hif.ex_redirect = 1'b0;
    #1; chk_ctl("rl_t", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rl_u", 1'b0, 1'b1, 1'b1);
    tick();
    #1; chk_ctl("rl_v", 1'b1, 1'b1, 1'b0);
    tick(); hif.id_uses_rs1 = 1'b0; hif.id_is_load = 1'b1;
    #1; chk_ctl("rl_w2ld", 1'b1, 1'b1, 1'b0);
    tick(); hif.dmem_resp_valid = 1'b1;
    #1; chk_ctl("rl_x", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a flush with a load pending.
    tick(); idle(); ex_load(5'd4);
    tick(); ex_clear(); hif.ex_redirect = 1'b1;
    tick(); hif.ex_redirect = 1'b0;
    #1; chk_ctl("rs_flush", 1'b0, 1'b1, 1'b1);
    tick(); rst = 1'b1;
    hif.id_valid = 1'b1; hif.id_rs1 = 5'd4; hif.id_uses_rs1 = 1'b1;
    hif.wb_we = 1'b1; hif.wb_rd = 5'd4;
    #1; chk_ctl("rs_in", 1'b0, 1'b0, 1'b0);
    chk("rs_in.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_REG));
    tick(); rst = 1'b0; hif.wb_we = 1'b0;
    #1; chk_ctl("rs_out", 1'b0, 1'b0, 1'b0);
    chk("rs_out.fwd_a", 32'(hif.fwd_a_sel), 32'(FWD_REG));
`ifdef HAZARD_PERF_CNT_EN
    chk("rs.perf_stall", perf_stall_cycles, 32'd0);
    chk("rs.perf_bubble", perf_bubble_cycles, 32'd0);
    chk("rs.perf_flush", perf_flush_events, 32'd0);
`endif

    tick(); idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
